// File: rtl/maquina_pkg.sv
// rtl/maquina_pkg.sv - shared state encoding, default sizes and pair indices for maquina_param
package maquina_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam int DEF_NUM_FIFOS     = 5;
    localparam int DEF_UMB_W         = 5;
    localparam int DEF_NUM_UMB_PAIRS = 3;

    localparam int PAIR_MF = 0;
    localparam int PAIR_VC = 1;
    localparam int PAIR_D  = 2;

endpackage

// File: rtl/umbral_regs.sv
// rtl/umbral_regs.sv - per-pair threshold capture registers and bajo<=alto consistency check
module umbral_regs
    import maquina_pkg::*;
#(
    parameter int UMB_W         = DEF_UMB_W,
    parameter int NUM_UMB_PAIRS = DEF_NUM_UMB_PAIRS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic [NUM_UMB_PAIRS*UMB_W-1:0] alto_in,
    input  logic [NUM_UMB_PAIRS*UMB_W-1:0] bajo_in,
    output logic [NUM_UMB_PAIRS*UMB_W-1:0] alto_q,
    output logic [NUM_UMB_PAIRS*UMB_W-1:0] bajo_q,
    output logic                           cfg_valid
);

    logic [NUM_UMB_PAIRS-1:0] pair_ok;

    genvar k;
    generate
        for (k = 0; k < NUM_UMB_PAIRS; k++) begin : g_pair
            logic [UMB_W-1:0] alto_r;
            logic [UMB_W-1:0] bajo_r;

            always_ff @(posedge clk) begin
                if (reset) begin
                    alto_r <= '0;
                    bajo_r <= '0;
                end else if (load) begin
                    alto_r <= alto_in[k*UMB_W +: UMB_W];
                    bajo_r <= bajo_in[k*UMB_W +: UMB_W];
                end
            end

            assign alto_q[k*UMB_W +: UMB_W] = alto_r;
            assign bajo_q[k*UMB_W +: UMB_W] = bajo_r;
            // Checked on the incoming values: the INIT exit decision uses what is captured on that same edge.
            assign pair_ok[k] = (bajo_in[k*UMB_W +: UMB_W] <= alto_in[k*UMB_W +: UMB_W]);
        end
    endgenerate

    assign cfg_valid = &pair_ok;

endmodule

// File: rtl/maquina_param.sv
// rtl/maquina_param.sv - FIFO supervisor FSM; optional error counter under MAQUINA_ERR_COUNT_EN
module maquina_param
    import maquina_pkg::*;
#(
    parameter int NUM_FIFOS     = DEF_NUM_FIFOS,
    parameter int UMB_W         = DEF_UMB_W,
    parameter int NUM_UMB_PAIRS = DEF_NUM_UMB_PAIRS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init,
    input  logic [NUM_UMB_PAIRS*UMB_W-1:0] umbral_alto,
    input  logic [NUM_UMB_PAIRS*UMB_W-1:0] umbral_bajo,
    input  logic [NUM_FIFOS-1:0]           fifo_empties,
    input  logic [NUM_FIFOS-1:0]           fifo_errors,
    output logic [NUM_UMB_PAIRS*UMB_W-1:0] umbral_alto_interno,
    output logic [NUM_UMB_PAIRS*UMB_W-1:0] umbral_bajo_interno,
    output logic                           error_out,
    output logic [NUM_FIFOS-1:0]           errors_out,
    output logic                           cfg_error_out,
    output logic                           active_out,
    output logic                           idle_out,
    output logic [STATE_W-1:0]             state_out
`ifdef MAQUINA_ERR_COUNT_EN
    ,
    output logic [7:0]                     err_count_out
`endif
);

    state_e               state;
    state_e               state_nxt;
    logic                 load;
    logic                 latch_en;
    logic                 cfg_set;
    logic                 cfg_valid;
    logic [NUM_FIFOS-1:0] errors_r;
    logic                 cfg_err_r;

    umbral_regs #(
        .UMB_W         (UMB_W),
        .NUM_UMB_PAIRS (NUM_UMB_PAIRS)
    ) u_umbral_regs (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .alto_in   (umbral_alto),
        .bajo_in   (umbral_bajo),
        .alto_q    (umbral_alto_interno),
        .bajo_q    (umbral_bajo_interno),
        .cfg_valid (cfg_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_RESET;
        load      = 1'b0;
        latch_en  = 1'b0;
        cfg_set   = 1'b0;
        case (state)
            ST_RESET: state_nxt = ST_INIT;
            ST_INIT: begin
                load = 1'b1;
                if (init) begin
                    state_nxt = ST_INIT;
                end else if (!cfg_valid) begin
                    state_nxt = ST_ERROR;
                    cfg_set   = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE, ST_ACTIVE: begin
                latch_en = 1'b1;
                // A FIFO error outranks a re-init request arriving on the same edge.
                if (|fifo_errors) begin
                    state_nxt = ST_ERROR;
                end else if (init) begin
                    state_nxt = ST_INIT;
                end else if (&fifo_empties) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                latch_en  = 1'b1;
                state_nxt = ST_ERROR;
            end
            default: state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            errors_r  <= '0;
            cfg_err_r <= 1'b0;
        end else begin
            if (latch_en) begin
                errors_r <= errors_r | fifo_errors;
            end
            if (cfg_set) begin
                cfg_err_r <= 1'b1;
            end
        end
    end

`ifdef MAQUINA_ERR_COUNT_EN
    logic [7:0]           err_count;
    logic [NUM_FIFOS-1:0] new_bits;
    logic [8:0]           err_sum;

    assign new_bits = fifo_errors & ~errors_r;
    assign err_sum  = {1'b0, err_count} + 9'($countones(new_bits));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (latch_en) begin
            err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign err_count_out = err_count;
`endif

    assign errors_out    = errors_r;
    assign cfg_error_out = cfg_err_r;
    assign error_out     = (state == ST_ERROR);
    assign active_out    = (state == ST_ACTIVE);
    assign idle_out      = (state == ST_IDLE);
    assign state_out     = state;

endmodule

// File: tb/tb_maquina_param.sv
// tb/tb_maquina_param.sv - directed and randomized checks of maquina_param against a behavioural model
module tb_maquina_param;

    localparam int N = 5;
    localparam int W = 5;
    localparam int P = 3;
    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;
    localparam int M_ERROR  = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           init;
    logic [P*W-1:0] ua;
    logic [P*W-1:0] ub;
    logic [N-1:0]   femp;
    logic [N-1:0]   fe;
    logic [P*W-1:0] ua_int;
    logic [P*W-1:0] ub_int;
    logic           error_out;
    logic [N-1:0]   errors_out;
    logic           cfg_error_out;
    logic           active_out;
    logic           idle_out;
    logic [2:0]     state_out;
`ifdef MAQUINA_ERR_COUNT_EN
    logic [7:0]     err_count_out;
`endif

    int checks = 0;
    int passed = 0;

    int           m_state;
    logic [W-1:0] m_alto [P];
    logic [W-1:0] m_bajo [P];
    logic [N-1:0] m_errs;
    logic         m_cfg;
    int           m_cnt;

    always #5 clk = ~clk;

    maquina_param dut (
        .clk                 (clk),
        .reset               (reset),
        .init                (init),
        .umbral_alto         (ua),
        .umbral_bajo         (ub),
        .fifo_empties        (femp),
        .fifo_errors         (fe),
        .umbral_alto_interno (ua_int),
        .umbral_bajo_interno (ub_int),
        .error_out           (error_out),
        .errors_out          (errors_out),
        .cfg_error_out       (cfg_error_out),
        .active_out          (active_out),
        .idle_out            (idle_out),
        .state_out           (state_out)
`ifdef MAQUINA_ERR_COUNT_EN
        ,
        .err_count_out       (err_count_out)
`endif
    );

    // Reference behaviour of one rising edge, evaluated from the inputs present at that edge.
    task automatic model_step();
        logic bad;
        if (reset) begin
            m_state = M_RESET;
            for (int k = 0; k < P; k++) begin
                m_alto[k] = '0;
                m_bajo[k] = '0;
            end
            m_errs = '0;
            m_cfg  = 1'b0;
            m_cnt  = 0;
            return;
        end
        if (m_state == M_IDLE || m_state == M_ACTIVE || m_state == M_ERROR) begin
            m_cnt = m_cnt + $countones(fe & ~m_errs);
            if (m_cnt > 255) m_cnt = 255;
            m_errs = m_errs | fe;
        end
        case (m_state)
            M_RESET: m_state = M_INIT;
            M_INIT: begin
                bad = 1'b0;
                for (int k = 0; k < P; k++) begin
                    m_alto[k] = ua[k*W +: W];
                    m_bajo[k] = ub[k*W +: W];
                    if (m_bajo[k] > m_alto[k]) bad = 1'b1;
                end
                if (!init) begin
                    if (bad) begin
                        m_state = M_ERROR;
                        m_cfg   = 1'b1;
                    end else begin
                        m_state = M_IDLE;
                    end
                end
            end
            M_IDLE, M_ACTIVE: begin
                if (fe != 0)              m_state = M_ERROR;
                else if (init)            m_state = M_INIT;
                else if (femp == {N{1'b1}}) m_state = M_IDLE;
                else                      m_state = M_ACTIVE;
            end
            M_ERROR: m_state = M_ERROR;
            default: m_state = M_RESET;
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_pair(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        ua[k*W +: W] = a;
        ub[k*W +: W] = b;
    endtask

    task automatic load_default_and_idle();
        reset = 1'b1; init = 1'b0; fe = '0; femp = '1;
        cycle();
        reset = 1'b0; init = 1'b1;
        set_pair(0, 5'd20, 5'd4);
        set_pair(1, 5'd18, 5'd6);
        set_pair(2, 5'd16, 5'd2);
        cycle();
        cycle();
        init = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b1; fe = '1; femp = '0; ua = '1; ub = '1;
        cycle();
        cycle();
        checks++;
        if ({state_out, error_out, active_out, idle_out, cfg_error_out} !== 7'd0 ||
            errors_out !== '0 || ua_int !== '0 || ub_int !== '0) begin
            $display("FAIL reset_outputs: state=%0d err=%b act=%b idle=%b cfg=%b errs=%b alto=%h bajo=%h, required all zero",
                     state_out, error_out, active_out, idle_out, cfg_error_out, errors_out, ua_int, ub_int);
        end else passed++;
`ifdef MAQUINA_ERR_COUNT_EN
        checks++;
        if (err_count_out !== 8'd0) $display("FAIL reset_count: got %0d required 0", err_count_out);
        else passed++;
`endif
        reset = 1'b0; init = 1'b0; fe = '0; femp = '1;
        cycle();
        checks++;
        if (state_out !== 3'd1) $display("FAIL reset_to_init: state=%0d required 1", state_out);
        else passed++;
    endtask

    task automatic test_init_capture();
        load_default_and_idle();
        checks++;
        if (ua_int !== {5'd16, 5'd18, 5'd20} || ub_int !== {5'd2, 5'd6, 5'd4})
            $display("FAIL capture: alto=%h bajo=%h required %h %h", ua_int, ub_int,
                     {5'd16, 5'd18, 5'd20}, {5'd2, 5'd6, 5'd4});
        else passed++;
        checks++;
        if (idle_out !== 1'b1 || state_out !== 3'd2 || cfg_error_out !== 1'b0)
            $display("FAIL init_to_idle: idle=%b state=%0d cfg=%b required 1 2 0", idle_out, state_out, cfg_error_out);
        else passed++;
    endtask

    task automatic test_empties();
        femp = 5'b11011;
        cycle();
        checks++;
        if (active_out !== 1'b1 || idle_out !== 1'b0)
            $display("FAIL go_active: active=%b idle=%b required 1 0", active_out, idle_out);
        else passed++;
        femp = 5'b11111;
        cycle();
        checks++;
        if (idle_out !== 1'b1 || active_out !== 1'b0)
            $display("FAIL back_idle: active=%b idle=%b required 0 1", active_out, idle_out);
        else passed++;
    endtask

    task automatic test_error_pulse();
        femp = 5'b01111;
        cycle();
        fe = 5'b00100;
        cycle();
        fe = '0;
        checks++;
        if (error_out !== 1'b1 || errors_out !== 5'b00100 || active_out !== 1'b0)
            $display("FAIL error_latch: err=%b errs=%b act=%b required 1 00100 0", error_out, errors_out, active_out);
        else passed++;
        cycle();
        init = 1'b1;
        cycle();
        cycle();
        init = 1'b0;
        checks++;
        if (state_out !== 3'd4 || errors_out !== 5'b00100 || ua_int !== {5'd16, 5'd18, 5'd20})
            $display("FAIL error_absorbing: state=%0d errs=%b alto=%h required 4 00100 held", state_out, errors_out, ua_int);
        else passed++;
        fe = 5'b10000;
        cycle();
        fe = '0;
        checks++;
        if (errors_out !== 5'b10100) $display("FAIL error_accumulate: errs=%b required 10100", errors_out);
        else passed++;
    endtask

    task automatic test_cfg_error();
        reset = 1'b1; init = 1'b0; fe = '0; femp = '1;
        cycle();
        reset = 1'b0;
        cycle();
        set_pair(0, 5'd20, 5'd4);
        set_pair(1, 5'd3, 5'd9);
        set_pair(2, 5'd16, 5'd2);
        cycle();
        checks++;
        if (state_out !== 3'd4 || cfg_error_out !== 1'b1 || errors_out !== '0 || ub_int[W +: W] !== 5'd9)
            $display("FAIL cfg_error: state=%0d cfg=%b errs=%b vc_bajo=%0d required 4 1 0 9",
                     state_out, cfg_error_out, errors_out, ub_int[W +: W]);
        else passed++;
        // Equal thresholds are consistent.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        set_pair(1, 5'd7, 5'd7);
        cycle();
        checks++;
        if (state_out !== 3'd2 || cfg_error_out !== 1'b0)
            $display("FAIL cfg_equal_ok: state=%0d cfg=%b required 2 0", state_out, cfg_error_out);
        else passed++;
    endtask

    task automatic test_priority();
        load_default_and_idle();
        fe = 5'b00001; init = 1'b1;
        cycle();
        fe = '0; init = 1'b0;
        checks++;
        if (state_out !== 3'd4 || errors_out !== 5'b00001)
            $display("FAIL error_over_init: state=%0d errs=%b required 4 00001", state_out, errors_out);
        else passed++;
    endtask

    task automatic test_reset_mid();
        load_default_and_idle();
        femp = 5'b11110;
        cycle();
        reset = 1'b1;
        cycle();
        checks++;
        if ({state_out, error_out, active_out, idle_out, cfg_error_out} !== 7'd0 ||
            errors_out !== '0 || ua_int !== '0 || ub_int !== '0)
            $display("FAIL reset_mid: state=%0d act=%b alto=%h bajo=%h required all zero",
                     state_out, active_out, ua_int, ub_int);
        else passed++;
        reset = 1'b0;
        cycle();
        checks++;
        if (state_out !== 3'd1) $display("FAIL reset_mid_init: state=%0d required 1", state_out);
        else passed++;
    endtask

`ifdef MAQUINA_ERR_COUNT_EN
    task automatic test_err_count();
        logic [7:0] exp_cnt [3];
        logic [N-1:0] pat [3];
        exp_cnt[0] = 8'd2; exp_cnt[1] = 8'd3; exp_cnt[2] = 8'd3;
        pat[0] = 5'b00011; pat[1] = 5'b00111; pat[2] = 5'b00111;
        load_default_and_idle();
        for (int i = 0; i < 3; i++) begin
            fe = pat[i];
            cycle();
            checks++;
            if (err_count_out !== exp_cnt[i])
                $display("FAIL err_count_%0d: got %0d required %0d", i, err_count_out, exp_cnt[i]);
            else passed++;
        end
        fe = '0;
    endtask
`endif

    task automatic test_random();
        logic [P*W-1:0] exp_a;
        logic [P*W-1:0] exp_b;
        reset = 1'b1;
        cycle();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 29) == 0);
            init  = ($urandom_range(0, 7) == 0);
            fe    = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            femp  = ($urandom_range(0, 1) == 0) ? '1 : N'($urandom);
            for (int k = 0; k < P; k++) begin
                ua[k*W +: W] = W'($urandom);
                ub[k*W +: W] = ($urandom_range(0, 7) == 0) ? W'($urandom)
                                                          : W'($urandom_range(0, int'(ua[k*W +: W])));
            end
            cycle();
            for (int k = 0; k < P; k++) begin
                exp_a[k*W +: W] = m_alto[k];
                exp_b[k*W +: W] = m_bajo[k];
            end
            checks++;
            if (state_out !== 3'(m_state) || idle_out !== (m_state == M_IDLE) ||
                active_out !== (m_state == M_ACTIVE) || error_out !== (m_state == M_ERROR))
                $display("FAIL rand_state[%0d]: state=%0d idle=%b act=%b err=%b required state %0d",
                         i, state_out, idle_out, active_out, error_out, m_state);
            else passed++;
            checks++;
            if (errors_out !== m_errs || cfg_error_out !== m_cfg)
                $display("FAIL rand_latch[%0d]: errs=%b cfg=%b required %b %b", i, errors_out, cfg_error_out, m_errs, m_cfg);
            else passed++;
            checks++;
            if (ua_int !== exp_a || ub_int !== exp_b)
                $display("FAIL rand_thr[%0d]: alto=%h bajo=%h required %h %h", i, ua_int, ub_int, exp_a, exp_b);
            else passed++;
`ifdef MAQUINA_ERR_COUNT_EN
            checks++;
            if (err_count_out !== 8'(m_cnt))
                $display("FAIL rand_count[%0d]: got %0d required %0d", i, err_count_out, m_cnt);
            else passed++;
`endif
        end
        reset = 1'b0; init = 1'b0; fe = '0; femp = '1;
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; fe = '0; femp = '1; ua = '0; ub = '0;
        m_state = M_RESET; m_errs = '0; m_cfg = 1'b0; m_cnt = 0;
        for (int k = 0; k < P; k++) begin
            m_alto[k] = '0;
            m_bajo[k] = '0;
        end
        test_reset();
        test_init_capture();
        test_empties();
        test_error_pulse();
        test_cfg_error();
        test_priority();
        test_reset_mid();
`ifdef MAQUINA_ERR_COUNT_EN
        test_err_count();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
